// File: rtl/if_id_fifo_if.sv
// Bundle of fetch-side and ID-side signals around the IF/ID decoupling queue.
//
// Handshake semantics: a fetch beat transfers on a rising edge when
// in_valid && in_ready (and no flush); the producer must hold the beat stable
// while in_valid is high and in_ready is low. The head entry is consumed on a
// rising edge when id_valid && id_allowin (and no flush). in_ready depends on
// occupancy only, never on id_allowin, so there is no combinational ready path.
interface if_id_fifo_if #(
    parameter int PC_W = 32
);
    // Fetch side
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            in_adel;
    logic            in_is_ds;

    // ID side
    logic            id_allowin;
    logic            id_valid;
    logic [PC_W-1:0] id_pc;
    logic [31:0]     id_inst;
    logic            id_adel;
    logic            id_is_ds;
    logic [5:0]      id_op;
    logic [5:0]      id_funct;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic [4:0]      id_rd;
    logic [4:0]      id_sa;
    logic [15:0]     id_imm;

    // Environment view: drives fetch beats and ID consumption
    modport master (
        output in_valid, in_pc, in_inst, in_adel, in_is_ds, id_allowin,
        input  in_ready, id_valid, id_pc, id_inst, id_adel, id_is_ds,
        input  id_op, id_funct, id_rs, id_rt, id_rd, id_sa, id_imm
    );

    // Queue view
    modport slave (
        input  in_valid, in_pc, in_inst, in_adel, in_is_ds, id_allowin,
        output in_ready, id_valid, id_pc, id_inst, id_adel, id_is_ds,
        output id_op, id_funct, id_rs, id_rt, id_rd, id_sa, id_imm
    );
endinterface

// File: rtl/if_id_fifo.sv
// IF/ID decoupling queue: DEPTH-entry circular buffer of fetched beats with
// a registered-only path (no fall-through), flush-to-empty on redirect, and
// the head instruction pre-split into decoder fields.
module if_id_fifo #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    if_id_fifo_if.slave      bus,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Pointer and occupancy state
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Entry storage; contents are don't-care while not counted as occupied
    logic [PC_W-1:0]  pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic             adel_mem_q [DEPTH];
    logic             ds_mem_q   [DEPTH];

    logic             can_accept;
    logic             head_valid;
    logic             push;
    logic             pop;
    logic [31:0]      head_inst;

    // Ready is a pure function of occupancy: a full queue refuses a beat even
    // when the head is being consumed in the same cycle.
    assign can_accept = (count_q < FULL_CNT);
    assign head_valid = (count_q != '0);

    // Flush wins over both sides of the handshake.
    assign push = bus.in_valid & can_accept & ~flush;
    assign pop  = head_valid & bus.id_allowin & ~flush;

    // Next-state for pointers and occupancy
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/occupancy registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write on accepted beat; storage itself is never cleared
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            pc_mem_q[wr_ptr_q]   <= bus.in_pc;
            inst_mem_q[wr_ptr_q] <= bus.in_inst;
            adel_mem_q[wr_ptr_q] <= bus.in_adel;
            ds_mem_q[wr_ptr_q]   <= bus.in_is_ds;
        end
    end

    // An empty queue presents an all-zero beat: inst 0 is sll $0,$0,0, a nop.
    assign head_inst    = head_valid ? inst_mem_q[rd_ptr_q] : 32'h0;

    assign bus.in_ready = can_accept;
    assign bus.id_valid = head_valid;
    assign bus.id_pc    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.id_inst  = head_inst;
    assign bus.id_adel  = head_valid ? adel_mem_q[rd_ptr_q] : 1'b0;
    assign bus.id_is_ds = head_valid ? ds_mem_q[rd_ptr_q] : 1'b0;

    // Decoder fields are plain slices of the head instruction
    assign bus.id_op    = head_inst[31:26];
    assign bus.id_rs    = head_inst[25:21];
    assign bus.id_rt    = head_inst[20:16];
    assign bus.id_rd    = head_inst[15:11];
    assign bus.id_sa    = head_inst[10:6];
    assign bus.id_funct = head_inst[5:0];
    assign bus.id_imm   = head_inst[15:0];

    assign count = count_q;
endmodule

// File: tb/tb_if_id_fifo.sv
// Bench for if_id_fifo: table of per-cycle vectors plus hand sequences for
// reset, latency, streaming and flush-with-reset; a queue of expected beats
// checks head contents and ordering.
module tb_if_id_fifo;
    localparam int DEPTH = 2;
    localparam int PC_W  = 32;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
        logic        ds;
    } beat_t;

    typedef struct {
        logic        fl;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
        logic        ds;
        logic        aw;
        int          exp_cnt;
    } vec_t;

    logic             clk;
    logic             resetn;
    logic             flush;
    logic [CNT_W-1:0] count;

    if_id_fifo_if #(.PC_W(PC_W)) bus ();

    if_id_fifo #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus),
        .count  (count)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec;
    int    n_fail;
    int    m_cnt;
    logic [65:0] exp_q[$];
    vec_t  vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model before the
    // edge, then advance the model at the edge.
    task automatic step(input logic fl, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic adel, input logic ds,
                        input logic aw, input int exp_cnt);
        beat_t e;
        beat_t nb;
        logic  do_push;
        logic  do_pop;
        flush          = fl;
        bus.in_valid   = v;
        bus.in_pc      = pc;
        bus.in_inst    = inst;
        bus.in_adel    = adel;
        bus.in_is_ds   = ds;
        bus.id_allowin = aw;
        @(negedge clk);
        if (exp_q.size() != 0) e = exp_q[0];
        else e = '0;
        chk("in_ready", 64'(bus.in_ready), 64'(m_cnt < DEPTH));
        chk("id_valid", 64'(bus.id_valid), 64'(m_cnt != 0));
        chk("count", 64'(count), 64'(m_cnt));
        if (exp_cnt >= 0) chk("count_tbl", 64'(count), 64'(exp_cnt));
        chk("id_pc", 64'(bus.id_pc), 64'(e.pc));
        chk("id_inst", 64'(bus.id_inst), 64'(e.inst));
        chk("id_adel", 64'(bus.id_adel), 64'(e.adel));
        chk("id_is_ds", 64'(bus.id_is_ds), 64'(e.ds));
        chk("id_op", 64'(bus.id_op), 64'(e.inst[31:26]));
        chk("id_rs", 64'(bus.id_rs), 64'(e.inst[25:21]));
        chk("id_rt", 64'(bus.id_rt), 64'(e.inst[20:16]));
        chk("id_rd", 64'(bus.id_rd), 64'(e.inst[15:11]));
        chk("id_sa", 64'(bus.id_sa), 64'(e.inst[10:6]));
        chk("id_funct", 64'(bus.id_funct), 64'(e.inst[5:0]));
        chk("id_imm", 64'(bus.id_imm), 64'(e.inst[15:0]));
        do_push = v && (m_cnt < DEPTH) && !fl;
        do_pop  = (m_cnt != 0) && aw && !fl;
        nb = '{pc: pc, inst: inst, adel: adel, ds: ds};
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(nb);
        end
        m_cnt = exp_q.size();
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt = 0;
    endtask

    initial begin
        logic [31:0] spc;
        n_vec  = 0;
        n_fail = 0;
        m_cnt  = 0;

        // Table: {flush, valid, pc, inst, adel, ds, allowin, expected count}
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1};
        vecs[1]  = '{1'b0, 1'b1, 32'h00000100, 32'h01095020, 1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b1, 32'h00000104, 32'h8D280004, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{1'b0, 1'b1, 32'h00000108, 32'h1509FFFE, 1'b0, 1'b0, 1'b0, 2};
        vecs[4]  = '{1'b0, 1'b1, 32'h00000108, 32'h1509FFFE, 1'b0, 1'b0, 1'b1, 2};
        vecs[5]  = '{1'b0, 1'b1, 32'h00000108, 32'h1509FFFE, 1'b0, 1'b0, 1'b1, 1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b0, 1'b1, 32'h00000200, 32'h3C01DEAD, 1'b0, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b0, 1'b1, 32'h00000204, 32'h34210BEE, 1'b0, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b1, 1'b1, 32'h00000208, 32'hAC220010, 1'b0, 1'b0, 1'b1, 2};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 0};
        vecs[12] = '{1'b0, 1'b1, 32'h00000003, 32'h42000018, 1'b1, 1'b1, 1'b0, 0};
        vecs[13] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 0};

        // Reset held three cycles with a beat offered
        resetn         = 1'b0;
        flush          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_pc      = 32'h12345678;
        bus.in_inst    = 32'hFFFFFFFF;
        bus.in_adel    = 1'b0;
        bus.in_is_ds   = 1'b0;
        bus.id_allowin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_id_inst", 64'(bus.id_inst), 64'd0);
        @(posedge clk);
        #1;

        // Latency: beat visible only the cycle after acceptance
        step(1'b0, 1'b1, 32'hBFC00000, 32'h3C08BFAF, 1'b0, 1'b0, 1'b0, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_id_valid", 64'(bus.id_valid), 64'd1);
        chk("lat_id_op", 64'(bus.id_op), 64'h0F);
        chk("lat_id_rt", 64'(bus.id_rt), 64'd8);
        chk("lat_id_imm", 64'(bus.id_imm), 64'hBFAF);
        chk("lat_id_pc", 64'(bus.id_pc), 64'hBFC00000);
        chk("lat_count", 64'(count), 64'd1);
        @(posedge clk);
        #1;

        // Table-driven: back-pressure, full refusal, flush, flags
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].fl, vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].adel,
                 vecs[i].ds, vecs[i].aw, vecs[i].exp_cnt);
        end

        // Streaming: one push and one pop per cycle, pointers wrap
        spc = 32'h00400000;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, spc, $urandom, 1'(i % 3 == 0), 1'(i % 2), 1'b1, (i == 0) ? 0 : 1);
            spc = spc + 32'd4;
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0);

        // Random mix of offers and consumption
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        // Flush together with reset mid-stream, refill afterwards
        model_reset();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step(1'b0, 1'b1, 32'h00000300, 32'h24020001, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 32'h00000304, 32'h24030002, 1'b0, 1'b0, 1'b0, 1);
        resetn         = 1'b0;
        flush          = 1'b1;
        bus.in_valid   = 1'b1;
        bus.id_allowin = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        flush  = 1'b0;
        model_reset();
        step(1'b0, 1'b1, 32'h00000400, 32'h00851021, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
